// File: rtl/health_pkg.sv
// Shared types for the health supervisor: FSM state encoding and crash counter width.
package health_pkg;

    localparam int CRASH_W = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WARN  = 2'd1,
        ST_RESET = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/health_ch_timer.sv
// One monitored channel: saturating idle timer plus its timeout flag.
module health_ch_timer #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic act,
    input  logic en,
    input  logic hold_clr,
    output logic fault
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] timer;

    always_ff @(posedge clk) begin
        if (rst || hold_clr || act || !en) begin
            timer <= '0;
        end else if (timer != TMO) begin
            timer <= timer + 1'b1;
        end
    end

    // Flag comes straight off the timer register; a disabled channel never reports.
    assign fault = (timer == TMO) && en;

endmodule

// File: rtl/health_supervisor.sv
// Watchdog-style supervisor: channel timeouts escalate RUN -> WARN -> RESET -> HOLD.
// Optional cause logging is enabled by defining HEALTH_CAUSE_LOG_EN.
module health_supervisor
    import health_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 10000000,
    parameter int WARN_CYC    = 1000000,
    parameter int RST_LEN     = 64,
    parameter int HOLDOFF     = 2000000,
    parameter int CRASH_LIMIT = 3,
    parameter int COOLDOWN    = 200000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_CH-1:0]  ch_act,
    input  logic [NUM_CH-1:0]  ch_en,
    input  logic               safe_clr,
    output logic               warn_irq,
    output logic               sys_reset_req,
    output logic               safe_mode,
    output logic [NUM_CH-1:0]  fault_vec,
    output logic [CRASH_W-1:0] crash_cnt,
    output logic [1:0]         state_o
`ifdef HEALTH_CAUSE_LOG_EN
    ,
    output logic [NUM_CH-1:0]  cause_vec,
    output logic               cause_valid
`endif
);

    localparam logic [CNT_W-1:0]   WARN_LAST = CNT_W'(WARN_CYC - 1);
    localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_LEN - 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0]   COOL_LAST = CNT_W'(COOLDOWN - 1);
    localparam logic [CRASH_W-1:0] LIMIT     = CRASH_W'(CRASH_LIMIT);

    function automatic logic [CRASH_W-1:0] sat_inc(input logic [CRASH_W-1:0] c);
        return (c >= LIMIT) ? LIMIT : c + 1'b1;
    endfunction

    function automatic logic [CRASH_W-1:0] sat_dec(input logic [CRASH_W-1:0] c);
        return (c == '0) ? '0 : c - 1'b1;
    endfunction

    state_t           state;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] cool_cnt;
    logic             any_fault;
    logic             escalate;
    logic             cool_run;
    logic             cool_done;
    logic             hold_clr;

    assign any_fault = |fault_vec;
    assign hold_clr  = (state == ST_HOLD);
    assign escalate  = (state == ST_WARN) && any_fault && (phase_cnt == WARN_LAST);
    assign cool_run  = (state == ST_RUN) && !any_fault && !safe_mode;
    assign cool_done = cool_run && (cool_cnt == COOL_LAST);
    assign warn_irq  = (state == ST_WARN);
    assign state_o   = state;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        health_ch_timer #(
            .CNT_W   (CNT_W),
            .TIMEOUT (TIMEOUT)
        ) u_timer (
            .clk      (clk),
            .rst      (rst),
            .act      (ch_act[i]),
            .en       (ch_en[i]),
            .hold_clr (hold_clr),
            .fault    (fault_vec[i])
        );
    end

    // One phase counter serves WARN, RESET and HOLD since they never overlap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_RUN;
            phase_cnt     <= '0;
            sys_reset_req <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    phase_cnt <= '0;
                    if (any_fault) begin
                        state <= ST_WARN;
                    end
                end
                ST_WARN: begin
                    if (!any_fault) begin
                        state     <= ST_RUN;
                        phase_cnt <= '0;
                    end else if (phase_cnt == WARN_LAST) begin
                        state         <= ST_RESET;
                        phase_cnt     <= '0;
                        sys_reset_req <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                ST_RESET: begin
                    if (phase_cnt == RST_LAST) begin
                        state         <= ST_HOLD;
                        phase_cnt     <= '0;
                        sys_reset_req <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                default: begin
                    if (phase_cnt == HOLD_LAST) begin
                        state     <= ST_RUN;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Software clear outranks both crash increment and the sticky safe-mode set.
    always_ff @(posedge clk) begin
        if (rst) begin
            cool_cnt  <= '0;
            crash_cnt <= '0;
            safe_mode <= 1'b0;
        end else begin
            if (cool_run) begin
                cool_cnt <= cool_done ? '0 : cool_cnt + 1'b1;
            end else if (state != ST_RUN) begin
                cool_cnt <= '0;
            end

            if (safe_clr) begin
                crash_cnt <= '0;
                safe_mode <= 1'b0;
            end else begin
                if (escalate) begin
                    crash_cnt <= sat_inc(crash_cnt);
                end else if (cool_done) begin
                    crash_cnt <= sat_dec(crash_cnt);
                end
                if (crash_cnt == LIMIT) begin
                    safe_mode <= 1'b1;
                end
            end
        end
    end

`ifdef HEALTH_CAUSE_LOG_EN
    always_ff @(posedge clk) begin
        if (rst || safe_clr) begin
            cause_vec   <= '0;
            cause_valid <= 1'b0;
        end else if (escalate) begin
            cause_vec   <= fault_vec;
            cause_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_health_supervisor.sv
// Directed table-driven bench for health_supervisor with shortened timing parameters.
module tb_health_supervisor;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ch_act;
    logic [3:0] ch_en;
    logic       safe_clr;
    logic       warn_irq;
    logic       sys_reset_req;
    logic       safe_mode;
    logic [3:0] fault_vec;
    logic [2:0] crash_cnt;
    logic [1:0] state_o;
`ifdef HEALTH_CAUSE_LOG_EN
    logic [3:0] cause_vec;
    logic       cause_valid;
`endif

    int errors = 0;
    int checks = 0;

    health_supervisor #(
        .NUM_CH      (4),
        .CNT_W       (32),
        .TIMEOUT     (16),
        .WARN_CYC    (8),
        .RST_LEN     (4),
        .HOLDOFF     (6),
        .CRASH_LIMIT (3),
        .COOLDOWN    (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ch_act        (ch_act),
        .ch_en         (ch_en),
        .safe_clr      (safe_clr),
        .warn_irq      (warn_irq),
        .sys_reset_req (sys_reset_req),
        .safe_mode     (safe_mode),
        .fault_vec     (fault_vec),
        .crash_cnt     (crash_cnt),
        .state_o       (state_o)
`ifdef HEALTH_CAUSE_LOG_EN
        ,
        .cause_vec     (cause_vec),
        .cause_valid   (cause_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] en;
        logic [3:0] act;
        logic       clr;
        int         n;
        logic [1:0] st;
        logic [3:0] flt;
        logic [2:0] crash;
        logic       safe;
        logic       req;
        logic       chk_cause;
        logic [3:0] cause;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic [3:0] en, input logic [3:0] act,
                       input logic clr, input int n, input logic [1:0] st,
                       input logic [3:0] flt, input logic [2:0] crash, input logic safe,
                       input logic req, input logic chk_cause, input logic [3:0] cause);
        vec_t v;
        v = '{r, en, act, clr, n, st, flt, crash, safe, req, chk_cause, cause};
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        rst = 1'b1; ch_en = 4'hF; ch_act = 4'hF; safe_clr = 1'b0;

        //   rst en    act   clr n   st flt   cr safe req cc cause
        add(1, 4'hF, 4'hF, 0, 2,  0, 4'h0, 0, 0, 0, 0, 4'h0);
        add(0, 4'hF, 4'hF, 0, 1,  0, 4'h0, 0, 0, 0, 0, 4'h0);
        add(0, 4'hF, 4'hE, 0, 15, 0, 4'h0, 0, 0, 0, 0, 4'h0);
        add(0, 4'hF, 4'hE, 0, 1,  0, 4'h1, 0, 0, 0, 0, 4'h0);
        add(0, 4'hF, 4'hE, 0, 1,  1, 4'h1, 0, 0, 0, 0, 4'h0);
        add(0, 4'hF, 4'hF, 0, 1,  1, 4'h0, 0, 0, 0, 0, 4'h0);
        add(0, 4'hF, 4'hF, 0, 1,  0, 4'h0, 0, 0, 0, 0, 4'h0);
        add(0, 4'hF, 4'hE, 0, 17, 1, 4'h1, 0, 0, 0, 0, 4'h0);
        add(0, 4'hF, 4'hE, 0, 7,  1, 4'h1, 0, 0, 0, 0, 4'h0);
        add(0, 4'hF, 4'hE, 0, 1,  2, 4'h1, 1, 0, 1, 1, 4'h1);
        add(0, 4'hF, 4'hE, 0, 3,  2, 4'h1, 1, 0, 1, 0, 4'h0);
        add(0, 4'hF, 4'hE, 0, 1,  3, 4'h1, 1, 0, 0, 0, 4'h0);
        add(0, 4'hF, 4'hE, 0, 1,  3, 4'h0, 1, 0, 0, 0, 4'h0);
        add(0, 4'hF, 4'hE, 0, 4,  3, 4'h0, 1, 0, 0, 0, 4'h0);
        add(0, 4'hF, 4'hE, 0, 1,  0, 4'h0, 1, 0, 0, 0, 4'h0);
        add(0, 4'hF, 4'hE, 0, 25, 2, 4'h1, 2, 0, 1, 0, 4'h0);
        add(0, 4'hF, 4'hE, 0, 10, 0, 4'h0, 2, 0, 0, 0, 4'h0);
        add(0, 4'hF, 4'hE, 0, 25, 2, 4'h1, 3, 0, 1, 0, 4'h0);
        add(0, 4'hF, 4'hE, 0, 1,  2, 4'h1, 3, 1, 1, 0, 4'h0);
        add(0, 4'hF, 4'hE, 0, 9,  0, 4'h0, 3, 1, 0, 0, 4'h0);
        add(0, 4'hF, 4'hE, 0, 25, 2, 4'h1, 3, 1, 1, 0, 4'h0);
        add(0, 4'hF, 4'hE, 1, 1,  2, 4'h1, 0, 0, 1, 1, 4'h0);
        add(0, 4'hF, 4'hF, 0, 9,  0, 4'h0, 0, 0, 0, 0, 4'h0);
        add(0, 4'hF, 4'hE, 0, 25, 2, 4'h1, 1, 0, 1, 0, 4'h0);
        add(0, 4'hF, 4'hE, 0, 10, 0, 4'h0, 1, 0, 0, 0, 4'h0);
        add(0, 4'hF, 4'hE, 0, 25, 2, 4'h1, 2, 0, 1, 0, 4'h0);
        add(0, 4'hF, 4'hF, 0, 10, 0, 4'h0, 2, 0, 0, 0, 4'h0);
        add(0, 4'hF, 4'hF, 0, 31, 0, 4'h0, 2, 0, 0, 0, 4'h0);
        add(0, 4'hF, 4'hF, 0, 1,  0, 4'h0, 1, 0, 0, 0, 4'h0);
        add(0, 4'hF, 4'hF, 0, 32, 0, 4'h0, 0, 0, 0, 0, 4'h0);
        add(0, 4'hF, 4'hF, 0, 32, 0, 4'h0, 0, 0, 0, 0, 4'h0);
        add(0, 4'hF, 4'h5, 0, 17, 1, 4'hA, 0, 0, 0, 0, 4'h0);
        add(0, 4'hF, 4'h5, 0, 8,  2, 4'hA, 1, 0, 1, 1, 4'hA);
        add(0, 4'hF, 4'h5, 0, 10, 0, 4'h0, 1, 0, 0, 0, 4'h0);
        add(0, 4'hF, 4'h5, 0, 25, 2, 4'hA, 2, 0, 1, 0, 4'h0);
        add(0, 4'hF, 4'h5, 0, 1,  2, 4'hA, 2, 0, 1, 0, 4'h0);
        add(1, 4'hF, 4'hF, 0, 1,  0, 4'h0, 0, 0, 0, 1, 4'h0);
        add(0, 4'hF, 4'hF, 0, 3,  0, 4'h0, 0, 0, 0, 0, 4'h0);
        add(0, 4'h0, 4'h0, 0, 20, 0, 4'h0, 0, 0, 0, 0, 4'h0);

        for (int i = 0; i < vq.size(); i++) begin
            rst = vq[i].rst; ch_en = vq[i].en; ch_act = vq[i].act; safe_clr = vq[i].clr;
            step(vq[i].n);
            chk($sformatf("v%0d state", i), int'(state_o), int'(vq[i].st));
            chk($sformatf("v%0d warn_irq", i), int'(warn_irq), (vq[i].st == 2'd1) ? 1 : 0);
            chk($sformatf("v%0d fault_vec", i), int'(fault_vec), int'(vq[i].flt));
            chk($sformatf("v%0d crash_cnt", i), int'(crash_cnt), int'(vq[i].crash));
            chk($sformatf("v%0d safe_mode", i), int'(safe_mode), int'(vq[i].safe));
            chk($sformatf("v%0d sys_reset_req", i), int'(sys_reset_req), int'(vq[i].req));
`ifdef HEALTH_CAUSE_LOG_EN
            if (vq[i].chk_cause) begin
                chk($sformatf("v%0d cause_vec", i), int'(cause_vec), int'(vq[i].cause));
                chk($sformatf("v%0d cause_valid", i), int'(cause_valid),
                    (vq[i].cause != 4'h0) ? 1 : 0);
            end
`endif
        end

        // Reset pulse width and HOLD length measured directly on a persistent fault.
        ch_en = 4'hF; ch_act = 4'hE; safe_clr = 1'b0;
        k = 0;
        while (!sys_reset_req && k < 100) begin step(1); k++; end
        chk("req rise", int'(sys_reset_req), 1);
        chk("crash after escalation", int'(crash_cnt), 1);
        k = 0;
        while (sys_reset_req && k < 20) begin step(1); k++; end
        chk("req width", k, 4);
        chk("state after reset pulse", int'(state_o), 3);
        k = 0;
        while (state_o == 2'd3 && k < 20) begin step(1); k++; end
        chk("hold length", k, 6);

        // safe_clr landing on the WARN->RESET edge must win over the increment.
        k = 0;
        while (state_o != 2'd1 && k < 100) begin step(1); k++; end
        chk("warn reached", int'(state_o), 1);
        step(7);
        chk("still warn", int'(state_o), 1);
        safe_clr = 1'b1;
        step(1);
        safe_clr = 1'b0;
        chk("clr vs inc state", int'(state_o), 2);
        chk("clr vs inc crash", int'(crash_cnt), 0);
        chk("clr vs inc safe", int'(safe_mode), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
